pcs_timer_bank: RTL and testbench

- Parametrised bank of independent down-count timers serving the EEE/LPI receive and transmit state machines: tq_timer, tw_timer, wf_timer and future per-lane timers.
- Generalises the single fixed-duration timer to N channels with run-time durations, one-shot or auto-reload mode, a shared tick enable and a per-channel timer_state_t status.
- Sits beside the RX/TX ordered-set state machines and is clocked by the PCS clock.

---
 rtl/pcs_pkg.sv | 20 ++
 rtl/pcs_timer_channel.sv | 95 +++++++++
 rtl/pcs_timer_bank.sv | 40 ++++
 tb/tb_pcs_timer_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS types and constants: timer channel status encoding,
// standard EEE/LPI timer durations and their channel slots in the timer bank.
package pcs_pkg;

   typedef enum logic [1:0] {
      TIMER_IDLE    = 2'b00,
      TIMER_RUNNING = 2'b01,
      TIMER_DONE    = 2'b10
   } timer_state_t;

   // Durations in 8 ns PCS ticks
   localparam int unsigned TQ_TIMER_VALUE = 2_750_000;
   localparam int unsigned TW_TIMER_VALUE = 1_375;
   localparam int unsigned WF_TIMER_VALUE = 125_000;

   localparam int unsigned TMR_TQ = 0;
   localparam int unsigned TMR_TW = 1;
   localparam int unsigned TMR_WF = 2;

endpackage

// File: rtl/pcs_timer_channel.sv
// One down-count timer channel: IDLE/RUNNING/DONE FSM plus remaining-count register,
// one-shot or auto-reload, counting only on cycles where the shared tick is high.
module pcs_timer_channel
   import pcs_pkg::*;
#(
   parameter int CNT_W = 22
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic [CNT_W-1:0] duration,
   output logic [1:0]       state,
   output logic             timer_done,
   output logic             done_pulse,
   output logic [CNT_W-1:0] count
);

   // start and stop are single-cycle strobes sampled at the clock edge;
   // start beats stop, and both beat a coinciding expiry (which then emits no pulse).
   timer_state_t     state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             pulse_q, pulse_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= TIMER_IDLE;
         count_q <= '0;
         mode_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      pulse_d = 1'b0;
      if (start) begin
         mode_d = auto_reload;
         if (duration == '0) begin
            state_d = TIMER_DONE;
            count_d = '0;
            pulse_d = 1'b1;
         end else begin
            state_d = TIMER_RUNNING;
            count_d = duration;
         end
      end else if (stop) begin
         state_d = TIMER_IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            TIMER_IDLE: ;
            TIMER_RUNNING: begin
               if (tick) begin
                  if (count_q > CNT_W'(1)) begin
                     count_d = count_q - CNT_W'(1);
                  end else begin
                     pulse_d = 1'b1;
                     // A periodic channel whose reload value is zero parks in DONE
                     if (mode_q && (duration != '0)) begin
                        count_d = duration;
                     end else begin
                        count_d = '0;
                        state_d = TIMER_DONE;
                     end
                  end
               end
            end
            TIMER_DONE: ;
            default: begin
               state_d = TIMER_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      state      = state_q;
      timer_done = (state_q == TIMER_DONE);
      done_pulse = pulse_q;
      count      = count_q;
   end

endmodule

// File: rtl/pcs_timer_bank.sv
// Bank of NUM_TIMERS independent PCS timer channels sharing one tick enable;
// per-channel controls and status are packed side by side, channel 0 in the low bits.
module pcs_timer_bank
   import pcs_pkg::*;
#(
   parameter int NUM_TIMERS = 3,
   parameter int CNT_W      = 22
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic [NUM_TIMERS-1:0]       start,
   input  logic [NUM_TIMERS-1:0]       stop,
   input  logic [NUM_TIMERS-1:0]       auto_reload,
   input  logic [NUM_TIMERS*CNT_W-1:0] duration,
   output logic [NUM_TIMERS*2-1:0]     timer_state,
   output logic [NUM_TIMERS-1:0]       timer_done,
   output logic [NUM_TIMERS-1:0]       done_pulse,
   output logic [NUM_TIMERS*CNT_W-1:0] count
);

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
      pcs_timer_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .start      (start[i]),
         .stop       (stop[i]),
         .auto_reload(auto_reload[i]),
         .duration   (duration[i*CNT_W +: CNT_W]),
         .state      (timer_state[i*2 +: 2]),
         .timer_done (timer_done[i]),
         .done_pulse (done_pulse[i]),
         .count      (count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_pcs_timer_bank.sv
// Bench for pcs_timer_bank: table of single-cycle vectors plus hand-written
// auto-reload, asynchronous reset and narrow-counter sequences.
module tb_pcs_timer_bank;
   import pcs_pkg::*;

   localparam int N  = 3;
   localparam int CW = 22;
   localparam int W  = 26;

   logic            clk = 1'b0;
   logic            reset;
   logic            tick;
   logic [N-1:0]    start, stop, auto_reload;
   logic [N*CW-1:0] duration;
   logic [N*2-1:0]  timer_state;
   logic [N-1:0]    timer_done, done_pulse;
   logic [N*CW-1:0] count;

   logic [0:0] s_start, s_stop, s_auto_reload;
   logic [3:0] s_duration;
   logic [1:0] s_state;
   logic [0:0] s_done, s_pulse;
   logic [3:0] s_count;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   typedef struct {
      int            ch;
      logic          st, sp, ar, tk;
      logic [CW-1:0] dur;
      logic [W-1:0]  exp;
   } vec_t;
   vec_t vecs[$];

   pcs_timer_bank #(.NUM_TIMERS(N), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
      .auto_reload(auto_reload), .duration(duration), .timer_state(timer_state),
      .timer_done(timer_done), .done_pulse(done_pulse), .count(count)
   );

   pcs_timer_bank #(.NUM_TIMERS(1), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .tick(tick), .start(s_start), .stop(s_stop),
      .auto_reload(s_auto_reload), .duration(s_duration), .timer_state(s_state),
      .timer_done(s_done), .done_pulse(s_pulse), .count(s_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] e(timer_state_t s, int c, bit p, bit d);
      return {s, CW'(c), p, d};
   endfunction

   function automatic logic [W-1:0] se(timer_state_t s, int c, bit p, bit d);
      return W'({s, 4'(c), p, d});
   endfunction

   function automatic logic [W-1:0] stat(int ch);
      return {timer_state[ch*2 +: 2], count[ch*CW +: CW], done_pulse[ch], timer_done[ch]};
   endfunction

   function automatic logic [W-1:0] sstat();
      return W'({s_state, s_count, s_pulse, s_done});
   endfunction

   function automatic void add(int ch, bit st, bit sp, bit ar, bit tk, int dur, logic [W-1:0] ex);
      vec_t v;
      v.ch = ch; v.st = st; v.sp = sp; v.ar = ar; v.tk = tk; v.dur = CW'(dur); v.exp = ex;
      vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pop(input string name, input logic [W-1:0] act);
      logic [W-1:0] ex;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got %h but expected queue is empty", name, act);
      end else begin
         ex = exp_q.pop_front();
         if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, ex);
         end
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      start = '0; stop = '0; auto_reload = '0;
      start[v.ch] = v.st;
      stop[v.ch] = v.sp;
      auto_reload[v.ch] = v.ar;
      duration[v.ch*CW +: CW] = v.dur;
      tick = v.tk;
      exp_q.push_back(v.exp);
      step();
      check_pop($sformatf("vec%0d_ch%0d", idx, v.ch), stat(v.ch));
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0;
      start = '0; stop = '0; auto_reload = '0; duration = '0;
      s_start = '0; s_stop = '0; s_auto_reload = '0; s_duration = '0;
      step(); step();
      for (int c = 0; c < N; c++) begin
         exp_q.push_back(e(TIMER_IDLE, 0, 0, 0));
         check_pop($sformatf("reset_ch%0d", c), stat(c));
      end
      reset = 1'b0;
      step();

      // One-shot duration 5, then DONE held for 10 cycles
      add(0, 1, 0, 0, 1, 5, e(TIMER_RUNNING, 5, 0, 0));
      for (int k = 4; k >= 1; k--) add(0, 0, 0, 0, 1, 5, e(TIMER_RUNNING, k, 0, 0));
      add(0, 0, 0, 0, 1, 5, e(TIMER_DONE, 0, 1, 1));
      for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 1, 5, e(TIMER_DONE, 0, 0, 1));
      // Restart from DONE, tick alternating: expiry 8 clocks after start
      add(0, 1, 0, 0, 1, 4, e(TIMER_RUNNING, 4, 0, 0));
      add(0, 0, 0, 0, 0, 4, e(TIMER_RUNNING, 4, 0, 0));
      add(0, 0, 0, 0, 1, 4, e(TIMER_RUNNING, 3, 0, 0));
      add(0, 0, 0, 0, 0, 4, e(TIMER_RUNNING, 3, 0, 0));
      add(0, 0, 0, 0, 1, 4, e(TIMER_RUNNING, 2, 0, 0));
      add(0, 0, 0, 0, 0, 4, e(TIMER_RUNNING, 2, 0, 0));
      add(0, 0, 0, 0, 1, 4, e(TIMER_RUNNING, 1, 0, 0));
      add(0, 0, 0, 0, 0, 4, e(TIMER_RUNNING, 1, 0, 0));
      add(0, 0, 0, 0, 1, 4, e(TIMER_DONE, 0, 1, 1));
      add(0, 0, 0, 0, 0, 4, e(TIMER_DONE, 0, 0, 1));
      // Stop mid-count, tick ignored in IDLE
      add(0, 1, 0, 0, 1, 6, e(TIMER_RUNNING, 6, 0, 0));
      add(0, 0, 0, 0, 1, 6, e(TIMER_RUNNING, 5, 0, 0));
      add(0, 0, 1, 0, 1, 6, e(TIMER_IDLE, 0, 0, 0));
      add(0, 0, 0, 0, 1, 6, e(TIMER_IDLE, 0, 0, 0));
      // Zero duration goes straight to DONE with a pulse
      add(0, 1, 0, 0, 1, 0, e(TIMER_DONE, 0, 1, 1));
      add(0, 0, 0, 0, 1, 0, e(TIMER_DONE, 0, 0, 1));
      add(0, 0, 1, 0, 1, 0, e(TIMER_IDLE, 0, 0, 0));
      // Channel 2: start+stop together, expiry vs start, expiry vs stop
      add(2, 1, 0, 0, 1, 3, e(TIMER_RUNNING, 3, 0, 0));
      add(2, 0, 0, 0, 1, 3, e(TIMER_RUNNING, 2, 0, 0));
      add(2, 1, 1, 0, 1, 9, e(TIMER_RUNNING, 9, 0, 0));
      add(2, 0, 0, 0, 0, 9, e(TIMER_RUNNING, 9, 0, 0));
      add(2, 1, 0, 0, 1, 2, e(TIMER_RUNNING, 2, 0, 0));
      add(2, 0, 0, 0, 1, 2, e(TIMER_RUNNING, 1, 0, 0));
      add(2, 1, 0, 0, 1, 7, e(TIMER_RUNNING, 7, 0, 0));
      add(2, 1, 0, 0, 1, 1, e(TIMER_RUNNING, 1, 0, 0));
      add(2, 0, 1, 0, 1, 1, e(TIMER_IDLE, 0, 0, 0));
      // Auto-reload with a zero reload value parks in DONE; restart from DONE has no pulse
      add(2, 1, 0, 1, 1, 2, e(TIMER_RUNNING, 2, 0, 0));
      add(2, 0, 0, 0, 1, 2, e(TIMER_RUNNING, 1, 0, 0));
      add(2, 0, 0, 0, 1, 0, e(TIMER_DONE, 0, 1, 1));
      add(2, 1, 0, 0, 1, 4, e(TIMER_RUNNING, 4, 0, 0));
      add(2, 0, 1, 0, 1, 4, e(TIMER_IDLE, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
      start = '0; stop = '0; auto_reload = '0;

      // Auto-reload channel 1, duration 3, stopped at cycle 7
      tick = 1'b1;
      auto_reload[1] = 1'b1; start[1] = 1'b1; duration[CW +: CW] = CW'(3);
      exp_q.push_back(e(TIMER_RUNNING, 3, 0, 0));
      step();
      check_pop("ar_start", stat(1));
      start = '0; auto_reload = '0;
      for (int k = 1; k <= 9; k++) begin
         stop[1] = (k == 7);
         if (k >= 7) exp_q.push_back(e(TIMER_IDLE, 0, 0, 0));
         else exp_q.push_back(e(TIMER_RUNNING, (k % 3 == 0) ? 3 : 3 - (k % 3), (k % 3 == 0), 0));
         step();
         check_pop($sformatf("ar_cyc%0d", k), stat(1));
      end
      stop = '0;

      // Asynchronous reset between edges at count 37
      start[0] = 1'b1; duration[CW-1:0] = CW'(40);
      step();
      start = '0;
      step(); step(); step();
      exp_q.push_back(e(TIMER_RUNNING, 37, 0, 0));
      check_pop("pre_rst", stat(0));
      #3 reset = 1'b1;
      #1;
      for (int c = 0; c < N; c++) begin
         exp_q.push_back(e(TIMER_IDLE, 0, 0, 0));
         check_pop($sformatf("async_rst_ch%0d", c), stat(c));
      end
      #2 reset = 1'b0;
      step(); step();
      for (int c = 0; c < N; c++) begin
         exp_q.push_back(e(TIMER_IDLE, 0, 0, 0));
         check_pop($sformatf("post_rst_ch%0d", c), stat(c));
      end

      // Narrow counter at its maximum value: counts 15 ticks, no wrap
      s_start = 1'b1; s_duration = 4'd15;
      exp_q.push_back(se(TIMER_RUNNING, 15, 0, 0));
      step();
      check_pop("max_start", sstat());
      s_start = '0;
      for (int k = 1; k <= 16; k++) begin
         if (k < 15) exp_q.push_back(se(TIMER_RUNNING, 15 - k, 0, 0));
         else if (k == 15) exp_q.push_back(se(TIMER_DONE, 0, 1, 1));
         else exp_q.push_back(se(TIMER_DONE, 0, 0, 1));
         step();
         check_pop($sformatf("max_cyc%0d", k), sstat());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
